exp_series_engine: RTL and testbench
====================================

// Module: exp_series_engine
// PURPOSE
//  Parametrised, streaming successor of the lab4 exp wrapper. After a w_start pulse it computes
//  e^x ~ sum_{k<N} x^k/k! (fixed point) for JOB_LEN samples taken via a valid/ready handshake.
//  It writes one result per sample to a downstream FIFO using wr_req/wr_full backpressure.
//  The term count N is chosen per job. Sits between the input formatter and the result memory.
// PARAMETERS
//  IN_W       16  input width; x is unsigned Q0.IN_W (0 <= x < 1)
//  MAX_TERMS   8  max series terms; ui width TW = $clog2(MAX_TERMS)
//  JOB_LEN     4  samples per w_start job (>=1)
//  FIFO_DEPTH  4  internal result buffer depth, power of 2 (only with EXP_OUT_FIFO_EN)
// PORTS
//  clk      in   1         clock, rising edge
//  rst      in   1         asynchronous, active-low reset
//  w_start  in   1         job start pulse; sampled only in IDLE
//  ui       in   TW        term count minus 1 (N = ui+1); latched on accepted w_start
//  vi       in   IN_W      sample x
//  vi_valid in   1         sample valid
//  vi_ready out  1         high in LOAD only; transfer = vi_valid & vi_ready
//  wr_full  in   1         downstream FIFO full
//  wr_req   out  1         write strobe; out valid while high
//  out      out  IN_W+2    result, unsigned Q2.IN_W
//  busy     out  1         high from cycle after accepted w_start until done
//  done     out  1         one-cycle pulse after the last write is accepted
// BEHAVIOUR
//  Reset: state=IDLE; vi_ready, wr_req, busy, done = 0; out = 0; all counters = 0.
//  FSM: IDLE -(w_start)-> LOAD -(vi handshake)-> CALC -(k==N-1)-> WRITE -(wr_req)->
//       LOAD if samples left, else DONE -> IDLE (1 cycle).
//  LOAD: on handshake, x<=vi, term<=1.0 (Q1.IN_W), acc<=0, k<=0.
//  CALC: 1 term/cycle. acc += (term*COEF[k])>>IN_W; term <= (term*x)>>IN_W; k++. Lasts N cycles.
//  Truncate every product; never round. acc/out are IN_W+2 bits, no overflow since sum < e.
//  COEF[k] = floor(2^IN_W / k!) in Q1.IN_W, so COEF[0] = 2^IN_W.
//  WRITE: wr_req = !wr_full (combinational from state); out = acc held stable for the whole state.
//  Unstalled latency, handshake to wr_req = N+1 cycles; throughput 1 sample per N+2 cycles.
//  Boundaries:
//   - w_start while busy: ignored; ui changes mid-job: ignored.
//   - vi_valid outside LOAD: ignored, no transfer.
//   - wr_full held: stay in WRITE indefinitely, out stable, no sample lost.
//   - ui=0: N=1, out = 1.0 for any x.
//   - JOB_LEN=1: WRITE -> DONE directly.
//   - rst low mid-job: immediate return to reset values; partial job discarded, no done.
// CONFIGURATION
//  EXP_OUT_FIFO_EN defined:
//   - WRITE pushes acc into the internal FIFO in one cycle (stalls only if that FIFO is full).
//   - wr_req = fifo_nonempty & !wr_full; out = FIFO head; pop on wr_req.
//   - done waits until the last job result has left the FIFO.
//  EXP_OUT_FIFO_EN undefined: WRITE drives wr_req/out directly as above. Ports are identical.
// STRUCTURE
//  Shared package exp_pkg:
//   - state enum {IDLE,LOAD,CALC,WRITE,DONE}
//   - function coef(k) returning floor(2^IN_W/k!)
//   - localparam Q_ONE = 1<<IN_W
//  Sub-module exp_out_fifo (sync FIFO, FIFO_DEPTH x IN_W+2), instantiated only under
//  EXP_OUT_FIFO_EN. Datapath and FSM stay in this module.
// TESTING (IN_W=16, JOB_LEN=4)
//  1. Reset: hold rst=0 3 cycles with junk inputs -> all outputs 0, vi_ready=0.
//  2. ui=3, x=0x0000 x4 -> four wr_req, out=0x10000 each; done pulses once; busy then falls.
//  3. ui=1, x=0x8000 -> out=0x18000.
//     ui=2, x=0x8000 -> out=0x1A000.
//     ui=3, x=0x8000 -> out=0x1A555.
//     Each first wr_req comes N+1 cycles after its handshake.
//  4. Backpressure: wr_full=1 for 10 cycles during WRITE -> wr_req=0, out stable; released ->
//     exactly one write, next LOAD follows.
//  5. w_start pulses mid-job and vi_valid in IDLE -> no effect; exactly 4 writes, 1 done.
//  6. rst low during CALC of sample 2 -> wr_req/busy 0 at once; a new job then runs cleanly
//     (repeat case 2).
//     With EXP_OUT_FIFO_EN, also hold wr_full=1 across the whole job -> 4 results drain in order.

Source files
------------

// File: rtl/exp_pkg.sv
// Shared definitions for the exp_series_engine slice.
//   state_e : engine FSM states
//   Q_ONE   : 1.0 in Q1.16, the default input width
//   coef()  : series coefficient floor(2^in_w / k!)
package exp_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, CALC, WRITE, DONE} state_e;

    localparam int unsigned DEF_IN_W = 16;
    localparam longint unsigned Q_ONE = 64'd1 << DEF_IN_W;

    // Elaboration-time helper; k stays small so the factorial fits in 64 bits.
    function automatic longint unsigned coef(longint unsigned k, longint unsigned in_w);
        longint unsigned fact;
        fact = 64'd1;
        for (longint unsigned i = 2; i <= k; i++) begin
            fact = fact * i;
        end
        return (64'd1 << in_w) / fact;
    endfunction

endpackage

// File: rtl/exp_out_fifo.sv
// Synchronous result FIFO used by exp_series_engine when EXP_OUT_FIFO_EN is defined.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   push, wdata  write request and data (ignored when full)
//   pop          read request (ignored when empty)
//   full, empty  status
//   rdata        head entry, valid while !empty
module exp_out_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      cnt_q;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rdata   = mem_q[rptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/exp_series_engine.sv
// Streaming e^x engine: after w_start, takes JOB_LEN samples x (Q0.IN_W) over a valid/ready
// handshake and writes sum_{k<N} x^k/k! (Q2.IN_W, truncated products) per sample downstream.
// Optional build macro: EXP_OUT_FIFO_EN buffers results in an internal exp_out_fifo.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   w_start, ui        job start pulse (IDLE only) and term count minus 1
//   vi, vi_valid       sample input; vi_ready high in LOAD
//   wr_full, wr_req    downstream backpressure and write strobe
//   out                result, valid while wr_req
//   busy, done         job in progress, one-cycle completion pulse
module exp_series_engine
    import exp_pkg::*;
#(
    parameter int unsigned IN_W       = 16,
    parameter int unsigned MAX_TERMS  = 8,
    parameter int unsigned JOB_LEN    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned TW        = $clog2(MAX_TERMS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_start,
    input  logic [TW-1:0]   ui,
    input  logic [IN_W-1:0] vi,
    input  logic            vi_valid,
    output logic            vi_ready,
    input  logic            wr_full,
    output logic            wr_req,
    output logic [IN_W+1:0] out,
    output logic            busy,
    output logic            done
);

    localparam int unsigned AW = IN_W + 2;
    localparam int unsigned CW = (JOB_LEN > 1) ? $clog2(JOB_LEN) : 1;
    localparam logic [IN_W:0] ONE = {1'b1, {IN_W{1'b0}}};

    if (JOB_LEN < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk
        $error("exp_series_engine: bad JOB_LEN or FIFO_DEPTH");
    end

    state_e          state_q, state_d;
    logic [IN_W-1:0] x_q;
    logic [IN_W:0]   term_q;
    logic [AW-1:0]   acc_q;
    logic [TW-1:0]   k_q, ui_q;
    logic [CW-1:0]   cnt_q;
    logic [IN_W:0]   coef_tab [MAX_TERMS];
    logic [AW-1:0]   acc_inc;
    logic [IN_W:0]   term_nxt;
    logic            wr_ok;    // WRITE may complete this cycle
    logic            drained;  // no result still waiting to leave the engine
    logic            last;

    for (genvar g = 0; g < MAX_TERMS; g++) begin : g_coef
        assign coef_tab[g] = (IN_W+1)'(coef(64'(g), 64'(IN_W)));
    end

    // Both products are truncated back to the fixed-point grid.
    assign acc_inc  = AW'(((2*IN_W+2)'(term_q) * (2*IN_W+2)'(coef_tab[k_q])) >> IN_W);
    assign term_nxt = (IN_W+1)'(((2*IN_W+1)'(term_q) * (2*IN_W+1)'(x_q)) >> IN_W);
    assign last     = (cnt_q == CW'(JOB_LEN - 1));

`ifdef EXP_OUT_FIFO_EN
    logic          fifo_full, fifo_empty;
    logic [AW-1:0] fifo_head;

    exp_out_fifo #(
        .WIDTH (AW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (state_q == WRITE),
        .wdata (acc_q),
        .pop   (wr_req),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (fifo_head)
    );

    assign wr_ok   = ~fifo_full;
    assign wr_req  = ~fifo_empty & ~wr_full;
    assign out     = fifo_head;
    assign drained = fifo_empty;
`else
    assign wr_ok   = ~wr_full;
    assign wr_req  = (state_q == WRITE) & ~wr_full;
    assign out     = acc_q;
    assign drained = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        vi_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (w_start) state_d = LOAD;
            end
            LOAD: begin
                vi_ready = 1'b1;
                busy     = 1'b1;
                if (vi_valid) state_d = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (k_q == ui_q) state_d = WRITE;
            end
            WRITE: begin
                busy = 1'b1;
                if (wr_ok) state_d = last ? DONE : LOAD;
            end
            DONE: begin
                busy = ~drained;
                done = drained;
                if (drained) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            term_q  <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            ui_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (w_start) begin
                        ui_q  <= ui;
                        cnt_q <= '0;
                    end
                end
                LOAD: begin
                    if (vi_valid) begin
                        x_q    <= vi;
                        term_q <= ONE;
                        acc_q  <= '0;
                        k_q    <= '0;
                    end
                end
                CALC: begin
                    acc_q  <= acc_q + acc_inc;
                    term_q <= term_nxt;
                    k_q    <= k_q + 1'b1;
                end
                WRITE: begin
                    if (wr_ok) cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_series_engine.sv
module tb_exp_series_engine;
    import exp_pkg::*;

    localparam int unsigned IN_W       = 16;
    localparam int unsigned MAX_TERMS  = 8;
    localparam int unsigned JOB_LEN    = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TW         = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            w_start = 1'b0;
    logic [TW-1:0]   ui = '0;
    logic [IN_W-1:0] vi = '0;
    logic            vi_valid = 1'b0;
    logic            vi_ready;
    logic            wr_full = 1'b0;
    logic            wr_req;
    logic [IN_W+1:0] out;
    logic            busy;
    logic            done;

    exp_series_engine #(
        .IN_W       (IN_W),
        .MAX_TERMS  (MAX_TERMS),
        .JOB_LEN    (JOB_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .w_start  (w_start),
        .ui       (ui),
        .vi       (vi),
        .vi_valid (vi_valid),
        .vi_ready (vi_ready),
        .wr_full  (wr_full),
        .wr_req   (wr_req),
        .out      (out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int              n_cmp = 0;
    int              n_bad = 0;
    longint unsigned exp_q[$];
    int              cyc = 0;
    int              hs_cyc = 0;
    int              cur_n = 1;
    bit              hs_pending = 0;
    bit              hs_stalled = 0;
    int              job_writes = 0;
    int              total_writes = 0;
    int              dones = 0;
    logic [IN_W+1:0] last_out = '0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Series sum straight from its definition, truncating every product.
    function automatic longint unsigned model_exp(int n, longint unsigned x);
        longint unsigned term, acc, fact;
        term = Q_ONE;
        acc  = 0;
        fact = 1;
        for (int k = 0; k < n; k++) begin
            if (k > 1) fact = fact * longint'(k);
            acc  = acc + ((term * (Q_ONE / fact)) >> IN_W);
            term = (term * x) >> IN_W;
        end
        return acc;
    endfunction

    // Compare process: every write against the model queue, plus latency and reset values.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            check("rst_wr_req", wr_req, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_vi_ready", vi_ready, 0);
            check("rst_out", out, 0);
            hs_pending = 0;
        end else begin
            if (vi_valid && vi_ready) begin
                hs_cyc     = cyc;
                hs_pending = 1;
                hs_stalled = 0;
            end
            if (hs_pending && wr_full) hs_stalled = 1;
            if (wr_req) begin
                check("wr_req_while_full", wr_full, 0);
                if (exp_q.size() == 0) begin
                    check("spurious_write", 1, 0);
                end else begin
                    check("out_value", out, exp_q.pop_front());
                end
                last_out = out;
                total_writes++;
                job_writes++;
                if (hs_pending && !hs_stalled) check("latency", cyc - hs_cyc, cur_n + 1);
                hs_pending = 0;
            end
            if (done) begin
                check("writes_before_done", job_writes, JOB_LEN);
                job_writes = 0;
                dones++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int u, input logic [4*IN_W-1:0] xv, input bit mid_junk,
                           input bit stall_first, input int abort_at);
        int wr0, dn0;
        bit ok;
        int t_hs;
        wr0 = total_writes;
        dn0 = dones;
        ui = TW'(u);
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        cur_n = u + 1;
        if (stall_first) wr_full = 1'b1;
        for (int s = 0; s < JOB_LEN; s++) begin
            vi = xv[s*IN_W +: IN_W];
            vi_valid = 1'b1;
            ok = 0;
            t_hs = 0;
            for (int t = 0; t < 100 && !ok; t++) begin
                @(negedge clk);
                if (s == 0 && t == 0) check("busy_after_start", busy, 1);
                if (vi_ready) begin
                    ok = 1;
                    t_hs = t;
                    exp_q.push_back(model_exp(cur_n, longint'(vi)));
                end
                tick();
            end
            vi_valid = 1'b0;
            vi = 16'hDEAD;
            if (!ok) begin
                check("handshake_timeout", 0, 1);
                return;
            end
            if (stall_first && s == 1) check("load_after_release", t_hs, 0);
            if (mid_junk) begin
                w_start = 1'b1;
                ui = ~TW'(u);
                tick();
                w_start = 1'b0;
            end
            if (stall_first && s == 0) begin
                repeat (cur_n) @(posedge clk);
                for (int t = 0; t < 10; t++) begin
                    @(negedge clk);
                    check("stall_wr_req", wr_req, 0);
                    check("stall_out", out, exp_q[0]);
                    check("stall_vi_ready", vi_ready, 0);
                end
                tick();
                wr_full = 1'b0;
                @(negedge clk);
                check("stall_release_write", wr_req, 1);
                tick();
            end
            if (s == abort_at) begin
                tick();
                tick();
                @(negedge clk);
                #2 rst = 1'b0;
                #1;
                check("abort_wr_req", wr_req, 0);
                check("abort_busy", busy, 0);
                check("abort_vi_ready", vi_ready, 0);
                check("abort_done", done, 0);
                exp_q.delete();
                job_writes = 0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
                tick();
                return;
            end
        end
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        check("done_seen", ok, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("job_writes", total_writes - wr0, JOB_LEN);
        check("job_dones", dones - dn0, 1);
        check("queue_empty", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Model pinned to hand-computed values.
        check("model_n4_x0", model_exp(4, 0), 64'h10000);
        check("model_n2_xh", model_exp(2, 64'h8000), 64'h18000);
        check("model_n3_xh", model_exp(3, 64'h8000), 64'h1A000);
        check("model_n4_xh", model_exp(4, 64'h8000), 64'h1A555);

        // Reset held with junk inputs.
        rst = 1'b0;
        w_start = 1'b1;
        vi_valid = 1'b1;
        vi = 16'hBEEF;
        ui = 3'd5;
        wr_full = 1'b1;
        repeat (3) tick();
        w_start = 1'b0;
        vi_valid = 1'b0;
        wr_full = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // x = 0 with four terms.
        run_job(3, {4{16'h0000}}, 0, 0, -1);
        check("case2_out", last_out, 18'h10000);

        // x = 0.5 with 2, 3, 4 terms.
        run_job(1, {4{16'h8000}}, 0, 0, -1);
        check("case3_n2", last_out, 18'h18000);
        run_job(2, {4{16'h8000}}, 0, 0, -1);
        check("case3_n3", last_out, 18'h1A000);
        run_job(3, {4{16'h8000}}, 0, 0, -1);
        check("case3_n4", last_out, 18'h1A555);

        // ui = 0 gives exactly 1.0 regardless of x.
        run_job(0, {16'hFFFF, 16'h1234, 16'h8000, 16'h0001}, 0, 0, -1);
        check("ui0_out", last_out, 18'h10000);

        // Backpressure on the first write of a job.
        run_job(3, {16'h4000, 16'hC000, 16'h0100, 16'hF000}, 0, 1, -1);

        // Junk vi_valid in IDLE, then w_start/ui junk mid-job.
        vi_valid = 1'b1;
        vi = 16'h7777;
        repeat (3) tick();
        vi_valid = 1'b0;
        run_job(7, {16'hFFFF, 16'h2000, 16'hAAAA, 16'h5555}, 1, 0, -1);

        // Reset during CALC of sample 2, then a clean rerun.
        run_job(3, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 0, 0, 2);
        run_job(3, {4{16'h0000}}, 0, 0, -1);
        check("case6_out", last_out, 18'h10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
